// File: rtl/progc_pipe.sv
// progc_pipe: word-addressed fetch PC with boot delay, redirect priority, stall and halt/resume.
// Define PC_HIST_EN to add a circular history of redirect source PCs.
module progc_pipe #(
    parameter int               PCLEN     = 32,
    parameter logic [PCLEN-1:0] RSTVEC    = '0,
    parameter int               BOOTCYC   = 2,
    parameter int               HISTDEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         pcsel_vld,
    input  logic [1:0]                   pcsel,
    input  logic [PCLEN-1:0]             targaddr,
    input  logic                         halt_req,
    input  logic                         resume,
    output logic [PCLEN-1:0]             pcOut,
    output logic [PCLEN-1:0]             pclink,
    output logic                         fetch_vld,
    output logic                         halted,
    input  logic [$clog2(HISTDEPTH)-1:0] hist_idx,
    output logic [PCLEN-1:0]             hist_pc,
    output logic [$clog2(HISTDEPTH):0]   hist_cnt
);

    localparam int HW  = $clog2(HISTDEPTH);
    localparam int BCW = $clog2(BOOTCYC + 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [PCLEN-1:0] pc_q, pc_d;
    logic [BCW-1:0]   boot_cnt_q, boot_cnt_d;
    logic             fetch_vld_q, fetch_vld_d;
    logic             halted_q, halted_d;
    logic             redirect;
    logic [PCLEN-1:0] target;

    assign redirect = pcsel_vld && (pcsel != 2'b00);
    assign target   = (pcsel == 2'b01) ? targaddr : pc_q + targaddr;

    // A redirect in RUN outranks stall and halt_req; halt_req still moves to HALT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            BOOT: begin
                pc_d = RSTVEC;
                if (boot_cnt_q == BCW'(BOOTCYC - 1)) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BCW'(1);
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_d = target;
                end else if (!stall && !halt_req) begin
                    pc_d = pc_q + PCLEN'(1);
                end
                if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        fetch_vld_d = (state_d == RUN);
        halted_d    = (state_d == HALT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RSTVEC;
            boot_cnt_q  <= '0;
            fetch_vld_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            boot_cnt_q  <= boot_cnt_d;
            fetch_vld_q <= fetch_vld_d;
            halted_q    <= halted_d;
        end
    end

    assign pcOut     = pc_q;
    assign pclink    = pc_q + PCLEN'(1);
    assign fetch_vld = fetch_vld_q;
    assign halted    = halted_q;

`ifdef PC_HIST_EN
    logic [PCLEN-1:0] hist_mem_q [HISTDEPTH];
    logic [PCLEN-1:0] hist_mem_d [HISTDEPTH];
    logic [HW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [HW:0]      cnt_q, cnt_d;
    logic [HW-1:0]    rd_ptr;
    logic             redirect_taken;

    assign redirect_taken = redirect && (state_q == RUN);

    // wr_ptr_q points at the slot the next redirect overwrites (the oldest once full).
    always_comb begin
        hist_mem_d = hist_mem_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        if (redirect_taken) begin
            hist_mem_d[wr_ptr_q] = pc_q;
            wr_ptr_d             = wr_ptr_q + HW'(1);
            if (cnt_q != (HW+1)'(HISTDEPTH)) begin
                cnt_d = cnt_q + (HW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HISTDEPTH; i++) begin
                hist_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            hist_mem_q <= hist_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rd_ptr   = wr_ptr_q - HW'(1) - hist_idx;
    assign hist_pc  = ({1'b0, hist_idx} < cnt_q) ? hist_mem_q[rd_ptr] : '0;
    assign hist_cnt = cnt_q;
`else
    logic unused_hist_idx;

    assign unused_hist_idx = ^hist_idx;
    assign hist_pc         = '0;
    assign hist_cnt        = '0;
`endif

endmodule

// File: tb/tb_progc_pipe.sv
// tb_progc_pipe: directed vector table, hand-written corner sequences and randomized
// traffic checked against a cycle-level behavioural model of the fetch PC.
module tb_progc_pipe;

    localparam int          PCLEN     = 32;
    localparam logic [31:0] RSTVEC    = 32'h0;
    localparam int          BOOTCYC   = 2;
    localparam int          HISTDEPTH = 4;
    localparam int          HW        = 2;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic              pcsel_vld = 1'b0;
    logic [1:0]        pcsel = 2'b00;
    logic [PCLEN-1:0]  targaddr = '0;
    logic              halt_req = 1'b0;
    logic              resume = 1'b0;
    logic [PCLEN-1:0]  pcOut;
    logic [PCLEN-1:0]  pclink;
    logic              fetch_vld;
    logic              halted;
    logic [HW-1:0]     hist_idx = '0;
    logic [PCLEN-1:0]  hist_pc;
    logic [HW:0]       hist_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_mode;
    int          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_hist[$];

    typedef struct {
        logic        stall;
        logic        vld;
        logic [1:0]  sel;
        logic [31:0] targ;
        logic        hreq;
        logic        res;
        logic [31:0] exp_pc;
        logic        exp_fv;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    progc_pipe #(
        .PCLEN    (PCLEN),
        .RSTVEC   (RSTVEC),
        .BOOTCYC  (BOOTCYC),
        .HISTDEPTH(HISTDEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .stall    (stall),
        .pcsel_vld(pcsel_vld),
        .pcsel    (pcsel),
        .targaddr (targaddr),
        .halt_req (halt_req),
        .resume   (resume),
        .pcOut    (pcOut),
        .pclink   (pclink),
        .fetch_vld(fetch_vld),
        .halted   (halted),
        .hist_idx (hist_idx),
        .hist_pc  (hist_pc),
        .hist_cnt (hist_cnt)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_BOOT;
        m_boot = 0;
        m_pc   = RSTVEC;
        m_hist.delete();
    endtask

    // One rising edge of the architectural behaviour, described by the state rules directly.
    task automatic model_step(input logic st, input logic vld, input logic [1:0] sel,
                              input logic [31:0] targ, input logic hreq, input logic res);
        if (m_mode == M_BOOT) begin
            m_boot++;
            if (m_boot == BOOTCYC) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (vld && sel != 2'b00) begin
                m_hist.push_front(m_pc);
                if (m_hist.size() > HISTDEPTH) void'(m_hist.pop_back());
                m_pc = (sel == 2'b01) ? targ : m_pc + targ;
            end else if (!st && !hreq) begin
                m_pc = m_pc + 32'd1;
            end
            if (hreq) m_mode = M_HALT;
        end else begin
            if (res) m_mode = M_RUN;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic vld, input logic [1:0] sel,
                                 input logic [31:0] targ, input logic hreq, input logic res);
        stall     = st;
        pcsel_vld = vld;
        pcsel     = sel;
        targaddr  = targ;
        halt_req  = hreq;
        resume    = res;
        @(posedge clock);
        model_step(st, vld, sel, targ, hreq, res);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] exp_link;
        logic [31:0] exp_hpc;
        int          exp_hcnt;
        int          idx;
        idx      = $urandom_range(0, HISTDEPTH - 1);
        hist_idx = HW'(idx);
        #1;
        exp_link = m_pc + 32'd1;
`ifdef PC_HIST_EN
        exp_hcnt = m_hist.size();
        exp_hpc  = (idx < m_hist.size()) ? m_hist[idx] : 32'h0;
`else
        exp_hcnt = 0;
        exp_hpc  = 32'h0;
`endif
        check({tag, " pcOut"},     64'(pcOut),     64'(m_pc));
        check({tag, " pclink"},    64'(pclink),    64'(exp_link));
        check({tag, " fetch_vld"}, 64'(fetch_vld), 64'(m_mode == M_RUN));
        check({tag, " halted"},    64'(halted),    64'(m_mode == M_HALT));
        check({tag, " hist_cnt"},  64'(hist_cnt),  64'(exp_hcnt));
        check({tag, " hist_pc"},   64'(hist_pc),   64'(exp_hpc));
    endtask

    task automatic doReset();
        reset     = 1'b1;
        stall     = 1'b0;
        pcsel_vld = 1'b0;
        pcsel     = 2'b00;
        targaddr  = '0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("reset pcOut",     64'(pcOut),     64'(RSTVEC));
        check("reset fetch_vld", 64'(fetch_vld), 64'd0);
        check("reset halted",    64'(halted),    64'd0);
        check("reset hist_cnt",  64'(hist_cnt),  64'd0);
    endtask

    task automatic addVec(input logic st, input logic vld, input logic [1:0] sel, input logic [31:0] targ,
                          input logic hreq, input logic res, input logic [31:0] pc, input logic fv,
                          input logic hl);
        vec_t v;
        v.stall = st; v.vld = vld; v.sel = sel; v.targ = targ; v.hreq = hreq; v.res = res;
        v.exp_pc = pc; v.exp_fv = fv; v.exp_halt = hl;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_link;
        logic        r_vld;
        logic [1:0]  r_sel;
        logic [31:0] r_targ;

        // Boot, sequential fetch, stall, redirect priority, halt/resume and wrap-around.
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h0,        0, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h0,        1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h1,        1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h2,        1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h3,        1, 0);
        addVec(0, 1, 2'b01, 32'h8,        0, 0, 32'h8,        1, 0);
        addVec(1, 0, 2'b00, 32'h0,        0, 0, 32'h8,        1, 0);
        addVec(1, 1, 2'b00, 32'h5,        0, 0, 32'h8,        1, 0);
        addVec(1, 0, 2'b00, 32'h0,        0, 0, 32'h8,        1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h9,        1, 0);
        addVec(0, 1, 2'b01, 32'h8,        0, 0, 32'h8,        1, 0);
        addVec(1, 1, 2'b10, 32'hFFFFFFFC, 0, 0, 32'h4,        1, 0);
        addVec(0, 1, 2'b01, 32'h40,       0, 0, 32'h40,       1, 0);
        addVec(0, 1, 2'b01, 32'h10,       0, 0, 32'h10,       1, 0);
        addVec(0, 1, 2'b11, 32'h6,        1, 0, 32'h16,       0, 1);
        addVec(1, 1, 2'b11, 32'h64,       0, 0, 32'h16,       0, 1);
        addVec(0, 1, 2'b01, 32'h99,       1, 0, 32'h16,       0, 1);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h16,       0, 1);
        addVec(1, 0, 2'b00, 32'h0,        0, 0, 32'h16,       0, 1);
        addVec(0, 1, 2'b10, 32'h3,        0, 0, 32'h16,       0, 1);
        addVec(0, 0, 2'b00, 32'h0,        0, 1, 32'h16,       1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h17,       1, 0);
        addVec(0, 0, 2'b00, 32'h0,        1, 0, 32'h17,       0, 1);
        addVec(0, 0, 2'b00, 32'h0,        1, 1, 32'h17,       1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h18,       1, 0);
        addVec(0, 1, 2'b01, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 0, 32'h0,        1, 0);
        addVec(0, 0, 2'b00, 32'h0,        0, 1, 32'h1,        1, 0);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stall, vecs[i].vld, vecs[i].sel, vecs[i].targ, vecs[i].hreq, vecs[i].res);
            exp_link = vecs[i].exp_pc + 32'd1;
            check($sformatf("vec%0d pcOut", i),     64'(pcOut),     64'(vecs[i].exp_pc));
            check($sformatf("vec%0d pclink", i),    64'(pclink),    64'(exp_link));
            check($sformatf("vec%0d fetch_vld", i), 64'(fetch_vld), 64'(vecs[i].exp_fv));
            check($sformatf("vec%0d halted", i),    64'(halted),    64'(vecs[i].exp_halt));
        end

        // Asynchronous reset mid-stall must take effect with no clock edge.
        applyStimulus(0, 1, 2'b01, 32'h20, 0, 0);
        applyStimulus(1, 0, 2'b00, 32'h0, 0, 0);
        check("midstall pcOut", 64'(pcOut), 64'h20);
        #2;
        reset = 1'b1;
        #1;
        check("async reset pcOut",     64'(pcOut),     64'(RSTVEC));
        check("async reset fetch_vld", 64'(fetch_vld), 64'd0);
        check("async reset halted",    64'(halted),    64'd0);
        doReset();

        // Five redirects from PCs 1,3,5,7,9 into a four-deep history.
        applyStimulus(0, 0, 2'b00, 32'h0, 0, 0);
        applyStimulus(0, 0, 2'b00, 32'h0, 0, 0);
        applyStimulus(0, 0, 2'b00, 32'h0, 0, 0);
        check("hist seq pcOut", 64'(pcOut), 64'h1);
        applyStimulus(0, 1, 2'b01, 32'h3, 0, 0);
        applyStimulus(0, 1, 2'b01, 32'h5, 0, 0);
        applyStimulus(0, 1, 2'b11, 32'h2, 0, 0);
        applyStimulus(0, 1, 2'b10, 32'h2, 0, 0);
        applyStimulus(0, 1, 2'b01, 32'h20, 0, 0);
        hist_idx = 2'd0;
        #1;
`ifdef PC_HIST_EN
        check("hist_cnt full", 64'(hist_cnt), 64'd4);
        check("hist idx0",     64'(hist_pc),  64'h9);
        hist_idx = 2'd3;
        #1;
        check("hist idx3",     64'(hist_pc),  64'h3);
`else
        check("hist_cnt off",  64'(hist_cnt), 64'd0);
        check("hist idx0 off", 64'(hist_pc),  64'h0);
        hist_idx = 2'd3;
        #1;
        check("hist idx3 off", 64'(hist_pc),  64'h0);
`endif

        // Randomized traffic against the behavioural model.
        doReset();
        for (int c = 0; c < 1000; c++) begin
            r_vld  = ($urandom_range(0, 99) < 40);
            r_sel  = 2'($urandom_range(0, 3));
            r_targ = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31)) - 32'd16 : $urandom;
            applyStimulus($urandom_range(0, 99) < 25, r_vld, r_sel, r_targ,
                          $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 30);
            checkOutput($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
